// File: rtl/barrido_display_bcd.sv
// Binary-to-BCD (sequential double-dabble) plus 4-digit multiplexed scan for the Nexys 3 display.
// Optional build macro BLANK_LEADING_ZEROS_EN darkens leading zero digits.
module barrido_display_bcd #(
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [BIN_W-1:0] valor,
    input  logic             load,
    output logic [3:0]       numero,
    output logic [3:0]       anodos,
    output logic             busy,
    output logic             overflow
);

    localparam int STEP_W = $clog2(BIN_W + 1);
    localparam int PRE_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(9999);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t            state, state_next;
    logic [BIN_W-1:0]  shift_reg, shift_next;
    logic [15:0]       scratch, scratch_next, scratch_adj;
    logic [STEP_W-1:0] step, step_next;
    logic              overflow_next;
    logic [3:0][3:0]   digits, digits_next;
    logic              sat;

    logic [PRE_W-1:0]  presc;
    logic              tick, tick_d;
    logic [1:0]        idx, idx_next;
    logic              blank_lead;
    logic [3:0]        digit_show;

    // Saturation compare is done at 32 bits so narrow BIN_W can never trigger it
    assign sat  = 32'(valor) > 32'd9999;
    assign busy = (state != IDLE);

    always_comb begin
        scratch_adj = scratch;
        for (int unsigned k = 0; k < 4; k++) begin
            if (scratch[4*k +: 4] >= 4'd5)
                scratch_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_next    = state;
        shift_next    = shift_reg;
        scratch_next  = scratch;
        step_next     = step;
        overflow_next = overflow;
        digits_next   = digits;
        case (state)
            IDLE: begin
                if (load) begin
                    shift_next    = sat ? MAX_VAL : valor;
                    overflow_next = sat;
                    scratch_next  = '0;
                    step_next     = '0;
                    state_next    = CONV;
                end
            end
            CONV: begin
                scratch_next = {scratch_adj[14:0], shift_reg[BIN_W-1]};
                shift_next   = shift_reg << 1;
                step_next    = step + STEP_W'(1);
                if (step == STEP_W'(BIN_W - 1))
                    state_next = DONE;
            end
            DONE: begin
                digits_next = scratch;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            step      <= '0;
            overflow  <= 1'b0;
            digits    <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            scratch   <= scratch_next;
            step      <= step_next;
            overflow  <= overflow_next;
            digits    <= digits_next;
        end
    end

    assign tick     = (presc == PRE_W'(REFRESH_DIV - 1));
    assign idx_next = idx + 2'd1;

    always_comb begin
        blank_lead = 1'b0;
`ifdef BLANK_LEADING_ZEROS_EN
        case (idx_next)
            2'd1:    blank_lead = (digits[3:1] == '0);
            2'd2:    blank_lead = (digits[3:2] == '0);
            2'd3:    blank_lead = (digits[3] == '0);
            default: blank_lead = 1'b0;
        endcase
`else
        blank_lead = 1'b0;
`endif
        digit_show = blank_lead ? 4'hF : digits[idx_next];
    end

    // Anodes trail numero by one edge to match the decoder's registered segments
    always_ff @(posedge CLK) begin
        if (reset) begin
            presc  <= '0;
            idx    <= '0;
            tick_d <= 1'b0;
            numero <= 4'hF;
            anodos <= 4'b1111;
        end else begin
            presc  <= tick ? '0 : presc + PRE_W'(1);
            tick_d <= tick;
            if (tick) begin
                idx    <= idx_next;
                numero <= digit_show;
            end
            if (tick_d)
                anodos <= ~(4'b0001 << idx);
        end
    end

endmodule

// File: tb/tb_barrido_display_bcd.sv
// Directed bench for barrido_display_bcd with REFRESH_DIV=4: table of conversions plus scan/reset corner sequences.
module tb_barrido_display_bcd;

    localparam int BIN_W = 14;
    localparam int RD    = 4;

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic [BIN_W-1:0] valor = '0;
    logic             load = 1'b0;
    logic [3:0]       numero;
    logic [3:0]       anodos;
    logic             busy;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    barrido_display_bcd #(.BIN_W(BIN_W), .REFRESH_DIV(RD)) dut (
        .CLK(CLK), .reset(reset), .valor(valor), .load(load),
        .numero(numero), .anodos(anodos), .busy(busy), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [BIN_W-1:0] v;
        logic [15:0]      bcd;
        logic             ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [3:0] shown(input logic [15:0] d, input int i);
        logic [15:0] hi;
        hi = d >> (4 * i);
`ifdef BLANK_LEADING_ZEROS_EN
        if (i != 0 && hi == 16'h0) return 4'hF;
`endif
        return hi[3:0];
    endfunction

    // Called at a negedge; returns at the negedge following the capture edge
    task automatic pulse_load(input logic [BIN_W-1:0] v);
        valor = v;
        load  = 1'b1;
        @(negedge CLK);
        load  = 1'b0;
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge CLK);
        end
    endtask

    // Waits for anodos to newly enter the given slot, so numero is fresh
    task automatic wait_slot_entry(input logic [3:0] target, output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (anodos === target && n < 40) begin n++; @(negedge CLK); end
        if (n >= 40) return;
        n = 0;
        while (anodos !== target && n < 40) begin n++; @(negedge CLK); end
        ok = (n < 40);
    endtask

    task automatic check_display(input logic [15:0] d, input string tag);
        bit ok;
        logic [3:0] target;
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            target = ~(4'b0001 << i);
            wait_slot_entry(target, ok);
            if (!ok) timeout($sformatf("%s_slot%0d", tag, i));
            else check($sformatf("%s_num%0d", tag, i), 32'(numero), 32'(shown(d, i)));
        end
    endtask

    initial begin
        int  n;
        bit  ok;

        vecs[0] = '{v: 14'd1234,  bcd: 16'h1234, ovf: 1'b0};
        vecs[1] = '{v: 14'd10000, bcd: 16'h9999, ovf: 1'b1};
        vecs[2] = '{v: 14'd42,    bcd: 16'h0042, ovf: 1'b0};
        vecs[3] = '{v: 14'd0,     bcd: 16'h0000, ovf: 1'b0};
        vecs[4] = '{v: 14'd9999,  bcd: 16'h9999, ovf: 1'b0};
        vecs[5] = '{v: 14'd7,     bcd: 16'h0007, ovf: 1'b0};
        vecs[6] = '{v: 14'd16383, bcd: 16'h9999, ovf: 1'b1};
        vecs[7] = '{v: 14'd5008,  bcd: 16'h5008, ovf: 1'b0};

        // Reset held three cycles
        repeat (3) @(negedge CLK);
        check("rst_numero", 32'(numero), 32'hF);
        check("rst_anodos", 32'(anodos), 32'b1111);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge CLK);
        check("pre_tick_numero", 32'(numero), 32'hF);
        @(negedge CLK);
        check("tick4_numero", 32'(numero), 32'(shown(16'h0000, 1)));
        check("tick4_anodos_lag", 32'(anodos), 32'b1111);
        @(negedge CLK);
        check("tick4_anodos", 32'(anodos), 32'b1101);

        for (int t = 0; t < 8; t++) begin
            pulse_load(vecs[t].v);
            wait_busy_low(n);
            check($sformatf("v%0d_busy_cycles", t), 32'(n), 32'd15);
            check($sformatf("v%0d_overflow", t), 32'(overflow), 32'(vecs[t].ovf));
            check_display(vecs[t].bcd, $sformatf("v%0d", t));
        end

        // load presented in the DONE cycle is dropped
        pulse_load(14'd3210);
        n = 1;
        while (n < 15) begin n++; @(negedge CLK); end
        check("done_busy_before", 32'(busy), 32'd1);
        valor = 14'd777;
        load  = 1'b1;
        @(negedge CLK);
        load  = 1'b0;
        check("done_busy_after", 32'(busy), 32'd0);
        @(negedge CLK);
        check("done_load_ignored", 32'(busy), 32'd0);
        check_display(16'h3210, "done");

        // load while converting is dropped
        pulse_load(14'd1234);
        repeat (2) @(negedge CLK);
        pulse_load(14'd5678);
        wait_busy_low(n);
        check("ign_busy_rest", 32'(n), 32'd12);
        check_display(16'h1234, "ign");

        // numero leads anodos by one cycle at a slot boundary
        wait_slot_entry(4'b1110, ok);
        if (!ok) timeout("lag_slot0");
        else begin
            repeat (3) @(negedge CLK);
            check("lag_numero_new", 32'(numero), 32'h3);
            check("lag_anodos_old", 32'(anodos), 32'b1110);
            @(negedge CLK);
            check("lag_anodos_new", 32'(anodos), 32'b1101);
            check("lag_numero_hold", 32'(numero), 32'h3);
        end

        // Reset after step 7 of a 9999 conversion
        pulse_load(14'd9999);
        repeat (7) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_numero", 32'(numero), 32'hF);
        check("midrst_anodos", 32'(anodos), 32'b1111);
        reset = 1'b0;
        check_display(16'h0000, "midrst");
        pulse_load(14'd5);
        wait_busy_low(n);
        check("post_rst_busy_cycles", 32'(n), 32'd15);
        check_display(16'h0005, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
